// File: rtl/processor_core_if.sv
// ---------------------------------------------------------------------------
// processor_core_if
// Instruction-memory handshake between the core and the memory.
//   imem_addr  [PC_W]     core -> memory, instruction address (the current pc)
//   imem_req   [1]        core -> memory, fetch request, held until accepted
//   imem_data  [INSTR_W]  memory -> core, instruction word
//   imem_valid [1]        memory -> core, instruction word is valid this cycle
// The master modport is the core side and the slave modport is the memory side.
// ---------------------------------------------------------------------------
interface processor_core_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 22
);
  logic [PC_W-1:0]    imem_addr;
  logic               imem_req;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_valid;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_data,
    output imem_valid
  );
endinterface

// File: rtl/processor_core.sv
// ---------------------------------------------------------------------------
// processor_core
// Multi-cycle processor core. A fetch/execute/writeback FSM drives a register
// array and an ALU, and maintains the flags, branching and a terminal halt state.
// Ports:
//   clk     in   1      master clock; all state changes on the rising edge
//   rst     in   1      synchronous active-high reset
//   imem    master     instruction fetch handshake (addr/req out, data/valid in)
//   pc      out  PC_W   current program counter
//   flags   out  3      {N,C,Z} from the last flag-setting ALU op
//   retire  out  1      one-cycle pulse in the writeback cycle of each instruction
//   halted  out  1      high while in the HALT state
// Instruction format, from msb to lsb: op(4) rd ra rb, with REG_ADDR_W bits per
// register field. The immediate is {ra,rb}, truncated or zero-extended to fit.
// ---------------------------------------------------------------------------
module processor_core #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 6,
  parameter int PC_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  processor_core_if.master       imem,
  output logic [PC_W-1:0]        pc,
  output logic [2:0]             flags,
  output logic                   retire,
  output logic                   halted
);
  localparam int INSTR_W = 4 + 3*REG_ADDR_W;
  localparam int NREGS   = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [INSTR_W-1:0]    instr;
  logic [DATA_W-1:0]     regs [NREGS];

  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] rd, ra, rb;
  logic [DATA_W-1:0]     imm_d;
  logic [PC_W-1:0]       imm_p;
  logic [DATA_W-1:0]     opa, opb;

  logic [DATA_W-1:0]     alu_result;
  logic                  alu_c;
  logic                  alu_reg_we;
  logic                  alu_flag_we;
  logic [PC_W-1:0]       alu_pc;

  logic [DATA_W-1:0]     wb_result;
  logic [2:0]            wb_flags;
  logic                  wb_reg_we;
  logic                  wb_flag_we;
  logic [PC_W-1:0]       wb_pc;

  logic                  req;

  assign op    = instr[INSTR_W-1 -: 4];
  assign rd    = instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
  assign ra    = instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign rb    = instr[REG_ADDR_W-1:0];
  assign imm_d = DATA_W'({ra, rb});
  assign imm_p = PC_W'({ra, rb});
  assign opa   = regs[ra];
  assign opb   = regs[rb];

  assign imem.imem_addr = pc;
  assign imem.imem_req  = req;

  // ALU and next-pc computation. Only meaningful in EXEC, where the results are
  // captured into the wb_* registers; BZ sees the flags left by the previous op.
  always_comb begin
    alu_result  = '0;
    alu_c       = 1'b0;
    alu_reg_we  = 1'b0;
    alu_flag_we = 1'b0;
    alu_pc      = pc + PC_W'(1);
    case (op)
      4'h1: begin {alu_c, alu_result} = {1'b0, opa} + {1'b0, opb}; alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'h2: begin alu_result = opa - opb; alu_c = (opa < opb); alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'h3: begin alu_result = opa & opb; alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'h4: begin alu_result = opa | opb; alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'h5: begin alu_result = opa ^ opb; alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'h6: begin alu_result = ~opa; alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'h7: begin alu_result = opa << 1; alu_c = opa[DATA_W-1]; alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'h8: begin alu_result = opa >> 1; alu_c = opa[0]; alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'h9: begin {alu_c, alu_result} = {1'b0, opa} + {{DATA_W{1'b0}}, 1'b1}; alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'hA: begin alu_result = opa - DATA_W'(1); alu_c = (opa == '0); alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'hB: begin alu_result = opa; alu_reg_we = 1'b1; alu_flag_we = 1'b1; end
      4'hC: begin alu_result = imm_d; alu_reg_we = 1'b1; end
      4'hD: begin if (flags[0]) alu_pc = imm_p; end
      4'hE: begin alu_pc = imm_p; end
      4'hF: begin alu_pc = pc; end
      default: begin end
    endcase
  end

  // Next-state and handshake/status outputs. Reset suppresses the fetch request
  // and the retire pulse even though the state register still holds its old value.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    retire     = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        req = 1'b1;
        if (imem.imem_valid) state_next = S_EXEC;
      end
      S_EXEC: state_next = S_WB;
      S_WB: begin
        retire     = 1'b1;
        state_next = (op == 4'hF) ? S_HALT : S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
    if (rst) begin
      req    = 1'b0;
      retire = 1'b0;
    end
  end

  // State, instruction latch, execute results and architectural updates. The
  // register file and flags are written only in WB, so operands read in EXEC
  // never collide with a write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      flags      <= '0;
      instr      <= '0;
      wb_result  <= '0;
      wb_flags   <= '0;
      wb_reg_we  <= 1'b0;
      wb_flag_we <= 1'b0;
      wb_pc      <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_FETCH: begin
          if (imem.imem_valid) instr <= imem.imem_data;
        end
        S_EXEC: begin
          wb_result  <= alu_result;
          wb_flags   <= {alu_result[DATA_W-1], alu_c, (alu_result == '0)};
          wb_reg_we  <= alu_reg_we;
          wb_flag_we <= alu_flag_we;
          wb_pc      <= alu_pc;
        end
        S_WB: begin
          if (wb_reg_we)  regs[rd] <= wb_result;
          if (wb_flag_we) flags    <= wb_flags;
          pc <= wb_pc;
        end
        default: begin end
      endcase
    end
  end
endmodule

// File: tb/tb_processor_core.sv
// ---------------------------------------------------------------------------
// tb_processor_core
// Directed bench for processor_core. A small program memory held in the bench
// answers fetches combinationally; imem_valid is driven from the bench so that
// fetch stalls can be inserted. Expected values are worked out by hand.
// ---------------------------------------------------------------------------
module tb_processor_core;
  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 6;
  localparam int PC_W       = 8;
  localparam int INSTR_W    = 4 + 3*REG_ADDR_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_in;
  logic [PC_W-1:0]    pc;
  logic [2:0]         flags;
  logic               retire;
  logic               halted;
  logic [INSTR_W-1:0] prog [256];

  int compared   = 0;
  int mismatched = 0;
  int cyc;

  processor_core_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  assign bus.imem_data  = prog[bus.imem_addr];
  assign bus.imem_valid = valid_in;

  processor_core #(
    .DATA_W(DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .PC_W(PC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem(bus.master),
    .pc(pc),
    .flags(flags),
    .retire(retire),
    .halted(halted)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic [5:0] rd,
                                             input logic [5:0] ra, input logic [5:0] rb);
    return {op, rd, ra, rb};
  endfunction

  function automatic logic [INSTR_W-1:0] immi(input logic [3:0] op, input logic [5:0] rd,
                                              input logic [7:0] imm);
    return enc(op, rd, {4'b0000, imm[7:6]}, imm[5:0]);
  endfunction

  // Advance one clock and settle 1 time unit past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive reset and valid, then run the given number of clocks.
  task automatic applyStimulus(input logic rst_v, input logic valid_v, input int cycles);
    rst      = rst_v;
    valid_in = valid_v;
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Step until retire is seen; returns how many clocks that took.
  task automatic waitRetire(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!retire && cycles < 40);
    if (!retire) checkOutput("retire_timeout", 32'(cycles), 32'd0);
  endtask

  // Complete n instructions and land in the following FETCH cycle.
  task automatic execN(input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      waitRetire(c);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = '0;
    prog[8'h00] = immi(4'hC, 6'd1, 8'h05);
    prog[8'h01] = immi(4'hC, 6'd2, 8'h03);
    prog[8'h02] = enc(4'h1, 6'd3, 6'd1, 6'd2);
    prog[8'h03] = immi(4'hC, 6'd4, 8'hFF);
    prog[8'h04] = immi(4'hC, 6'd5, 8'h01);
    prog[8'h05] = enc(4'h1, 6'd6, 6'd4, 6'd5);
    prog[8'h06] = immi(4'hC, 6'd7, 8'h00);
    prog[8'h07] = enc(4'h2, 6'd8, 6'd7, 6'd5);
    prog[8'h08] = enc(4'hA, 6'd9, 6'd5, 6'd0);
    prog[8'h09] = immi(4'hD, 6'd0, 8'h40);
    prog[8'h40] = enc(4'h9, 6'd10, 6'd5, 6'd0);
    prog[8'h41] = immi(4'hD, 6'd0, 8'h10);
    prog[8'h42] = immi(4'hE, 6'd0, 8'hFF);
    prog[8'hFF] = immi(4'hE, 6'd0, 8'h80);
    prog[8'h80] = immi(4'hE, 6'd0, 8'hFF);
    prog[8'h20] = enc(4'hF, 6'd0, 6'd0, 6'd0);

    // Reset state, with the request suppressed while reset is held.
    applyStimulus(1'b1, 1'b1, 2);
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_flags", 32'(flags), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_req", 32'(bus.imem_req), 32'h0);
    checkOutput("rst_retire", 32'(retire), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("fetch_req", 32'(bus.imem_req), 32'h1);
    checkOutput("fetch_addr", 32'(bus.imem_addr), 32'h0);

    // LDI r1,5; LDI r2,3; ADD r3,r1,r2 with retire every third cycle.
    waitRetire(cyc);
    checkOutput("first_retire_cycles", 32'(cyc), 32'd2);
    waitRetire(cyc);
    checkOutput("second_retire_cycles", 32'(cyc), 32'd3);
    waitRetire(cyc);
    checkOutput("third_retire_cycles", 32'(cyc), 32'd3);
    step();
    checkOutput("pc_after_add", 32'(pc), 32'h3);
    checkOutput("r1", 32'(dut.regs[1]), 32'h05);
    checkOutput("r2", 32'(dut.regs[2]), 32'h03);
    checkOutput("r3_add", 32'(dut.regs[3]), 32'h08);
    checkOutput("flags_add", 32'(flags), 32'b000);

    // ADD 0xFF+0x01 wraps with carry and zero.
    execN(3);
    checkOutput("r6_add_wrap", 32'(dut.regs[6]), 32'h00);
    checkOutput("flags_add_wrap", 32'(flags), 32'b011);
    execN(1);
    checkOutput("flags_after_ldi", 32'(flags), 32'b011);
    execN(1);
    checkOutput("r8_sub_borrow", 32'(dut.regs[8]), 32'hFF);
    checkOutput("flags_sub_borrow", 32'(flags), 32'b110);
    checkOutput("pc_before_stall", 32'(pc), 32'h08);

    // Fetch stall: the request and address hold while valid is low.
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("stall_req", 32'(bus.imem_req), 32'h1);
      checkOutput("stall_addr", 32'(bus.imem_addr), 32'h08);
      checkOutput("stall_retire", 32'(retire), 32'h0);
      checkOutput("stall_pc", 32'(pc), 32'h08);
    end
    valid_in = 1'b1;
    waitRetire(cyc);
    checkOutput("after_stall_cycles", 32'(cyc), 32'd2);
    step();
    checkOutput("r9_dec_zero", 32'(dut.regs[9]), 32'h00);
    checkOutput("flags_dec_zero", 32'(flags), 32'b001);

    // Branches: BZ taken, INC clears Z, BZ not taken, JMP chain, NOP wrap.
    execN(1);
    checkOutput("bz_taken_pc", 32'(pc), 32'h40);
    execN(1);
    checkOutput("r10_inc", 32'(dut.regs[10]), 32'h02);
    checkOutput("flags_inc", 32'(flags), 32'b000);
    execN(1);
    checkOutput("bz_not_taken_pc", 32'(pc), 32'h42);
    execN(1);
    checkOutput("jmp_to_ff_pc", 32'(pc), 32'hFF);
    execN(1);
    checkOutput("jmp_from_ff_pc", 32'(pc), 32'h80);
    prog[8'hFF] = '0;
    prog[8'h00] = immi(4'hE, 6'd0, 8'h20);
    execN(1);
    checkOutput("jmp_back_ff_pc", 32'(pc), 32'hFF);
    execN(1);
    checkOutput("nop_wrap_pc", 32'(pc), 32'h00);
    execN(1);
    checkOutput("jmp_halt_pc", 32'(pc), 32'h20);

    // HALT is terminal: no requests, pc frozen, no retire.
    waitRetire(cyc);
    step();
    checkOutput("halted", 32'(halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("halt_req", 32'(bus.imem_req), 32'h0);
      checkOutput("halt_pc", 32'(pc), 32'h20);
      checkOutput("halt_retire", 32'(retire), 32'h0);
      checkOutput("halt_hold", 32'(halted), 32'h1);
    end

    // Reset leaves HALT and clears the architectural state.
    prog[8'h00] = immi(4'hC, 6'd1, 8'h07);
    prog[8'h01] = enc(4'h1, 6'd5, 6'd1, 6'd1);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("rst2_req", 32'(bus.imem_req), 32'h0);
    checkOutput("rst2_pc", 32'(pc), 32'h0);
    checkOutput("rst2_halted", 32'(halted), 32'h0);
    checkOutput("rst2_r3", 32'(dut.regs[3]), 32'h0);
    checkOutput("rst2_r8", 32'(dut.regs[8]), 32'h0);
    checkOutput("rst2_flags", 32'(flags), 32'h0);
    rst = 1'b0;

    // Reset during EXEC of ADD r5 discards it.
    execN(1);
    checkOutput("r1_ldi7", 32'(dut.regs[1]), 32'h07);
    step();
    rst = 1'b1;
    step();
    checkOutput("rst_exec_retire", 32'(retire), 32'h0);
    checkOutput("rst_exec_r5", 32'(dut.regs[5]), 32'h0);
    checkOutput("rst_exec_pc", 32'(pc), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rst_exec_req", 32'(bus.imem_req), 32'h1);
    checkOutput("rst_exec_addr", 32'(bus.imem_addr), 32'h0);
    step();
    checkOutput("rst_exec_no_retire", 32'(retire), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
